// File: rtl/usr_pkg.sv
// usr_pkg: shared op-code and FSM state types
// for the usr_burst_shift register family.
package usr_pkg;

   typedef enum logic [2:0] {
      HOLD = 3'b000,
      SHR  = 3'b001,
      SHL  = 3'b010,
      LOAD = 3'b011,
      ROR  = 3'b100,
      ROL  = 3'b101,
      ASR  = 3'b110,
      CLR  = 3'b111
   } usr_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } usr_state_e;

endpackage

// File: rtl/usr_shift_step.sv
// usr_shift_step: combinational next-value
// function of the universal shift register.
module usr_shift_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic [WIDTH-1:0] q,
   input  usr_op_e          op,
   input  logic [WIDTH-1:0] d,
   input  logic [STEP-1:0]  sr_din,
   input  logic [STEP-1:0]  sl_din,
   output logic [WIDTH-1:0] q_nxt
);

   // select the next register value for the given op
   always_comb begin
      q_nxt = q;
      unique case (op)
         HOLD: q_nxt = q;
         SHR:  q_nxt = {sr_din, q[WIDTH-1:STEP]};
         SHL:  q_nxt = {q[WIDTH-STEP-1:0], sl_din};
         LOAD: q_nxt = d;
         ROR:  q_nxt = {q[STEP-1:0], q[WIDTH-1:STEP]};
         ROL:  q_nxt = {q[WIDTH-STEP-1:0], q[WIDTH-1 -: STEP]};
         ASR:  q_nxt = {{STEP{q[WIDTH-1]}}, q[WIDTH-1:STEP]};
         CLR:  q_nxt = '0;
      endcase
   end

endmodule

// File: rtl/usr_burst_shift.sv
// usr_burst_shift: parametrised universal shift register.
// Define USR_BURST_EN to build the self-timed burst engine.
module usr_burst_shift
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1,
   parameter int CW    = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] d,
   input  logic [STEP-1:0]  sr_din,
   input  logic [STEP-1:0]  sl_din,
   input  logic             start,
   input  logic             burst_dir,
   input  logic [CW-1:0]    burst_cnt,
   output logic [WIDTH-1:0] q,
   output logic [STEP-1:0]  right_dout,
   output logic [STEP-1:0]  left_dout,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] q_nxt;
   usr_op_e          op_eff;

   usr_shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .q      (q),
      .op     (op_eff),
      .d      (d),
      .sr_din (sr_din),
      .sl_din (sl_din),
      .q_nxt  (q_nxt)
   );

   assign right_dout = q[STEP-1:0];
   assign left_dout  = q[WIDTH-1 -: STEP];

`ifdef USR_BURST_EN

   usr_state_e    state;
   logic          dir_q;
   logic [CW-1:0] remaining;
   logic          accept;

   assign accept = (state == IDLE) && start
                 && (burst_cnt != '0);

   // in RUN the latched direction overrides op
   always_comb begin
      op_eff = usr_op_e'(op);
      if (state == RUN)
         op_eff = dir_q ? SHL : SHR;
   end

   // burst FSM with registered q, busy and done
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         q         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dir_q     <= 1'b0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  dir_q     <= burst_dir;
                  remaining <= burst_cnt;
               end else begin
                  q <= q_nxt;
               end
            end
            RUN: begin
               q         <= q_nxt;
               remaining <= remaining - CW'(1);
               if (remaining == CW'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
         endcase
      end
   end

`else

   logic unused_burst;
   assign unused_burst = ^{start, burst_dir, burst_cnt};

   assign op_eff = usr_op_e'(op);
   assign busy   = 1'b0;
   assign done   = 1'b0;

   // op is applied on every cycle
   always_ff @(posedge clk) begin
      if (!reset_n)
         q <= '0;
      else
         q <= q_nxt;
   end

`endif

endmodule

// File: tb/tb_usr_burst_shift.sv
// tb_usr_burst_shift: randomized self-checking bench
// with a behavioural model, for STEP=1 and STEP=2.
module tb_usr_burst_shift;

`ifdef USR_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] op;
   logic [7:0] d;
   logic [1:0] srv, slv;
   logic       start, burst_dir;
   logic [3:0] burst_cnt;

   logic [7:0] q1, q2;
   logic [0:0] rd1, ld1;
   logic [1:0] rd2, ld2;
   logic       busy1, done1, busy2, done2;

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   logic [7:0] mq1, mq2;
   int         left_n;
   logic       mdir, mdone;

   always #5 clk = ~clk;

   usr_burst_shift #(.WIDTH(8), .STEP(1)) u1 (
      .clk(clk), .reset_n(reset_n), .op(op), .d(d),
      .sr_din(srv[0]), .sl_din(slv[0]),
      .start(start), .burst_dir(burst_dir),
      .burst_cnt(burst_cnt),
      .q(q1), .right_dout(rd1), .left_dout(ld1),
      .busy(busy1), .done(done1)
   );

   usr_burst_shift #(.WIDTH(8), .STEP(2)) u2 (
      .clk(clk), .reset_n(reset_n), .op(op), .d(d),
      .sr_din(srv), .sl_din(slv),
      .start(start), .burst_dir(burst_dir),
      .burst_cnt(burst_cnt),
      .q(q2), .right_dout(rd2), .left_dout(ld2),
      .busy(busy2), .done(done2)
   );

   function automatic logic [7:0] f(
      input logic [7:0] q, input logic [2:0] o,
      input logic [7:0] dd, input int s,
      input logic [1:0] sr, input logic [1:0] sl);
      int qi, m, r;
      qi = int'(q);
      m  = (1 << s) - 1;
      case (o)
         3'd1: r = (qi >> s) | ((int'(sr) & m) << (8 - s));
         3'd2: r = (qi << s) | (int'(sl) & m);
         3'd3: r = int'(dd);
         3'd4: r = (qi >> s) | (qi << (8 - s));
         3'd5: r = (qi << s) | (qi >> (8 - s));
         3'd6: r = q[7] ? ((qi >> s) | (256 - (256 >> s)))
                        : (qi >> s);
         3'd7: r = 0;
         default: r = qi;
      endcase
      return 8'(r & 255);
   endfunction

   task automatic chk(input string name,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  name, got, exp);
      end
   endtask

   task automatic model_edge();
      if (!reset_n) begin
         mq1 = 8'h00; mq2 = 8'h00;
         left_n = 0; mdone = 1'b0;
      end else begin
         mdone = 1'b0;
         if (left_n > 0) begin
            mq1 = f(mq1, mdir ? 3'd2 : 3'd1, d, 1, srv, slv);
            mq2 = f(mq2, mdir ? 3'd2 : 3'd1, d, 2, srv, slv);
            left_n--;
            if (left_n == 0) mdone = 1'b1;
         end else if (BURST && start && burst_cnt != 0) begin
            left_n = int'(burst_cnt);
            mdir   = burst_dir;
         end else begin
            mq1 = f(mq1, op, d, 1, srv, slv);
            mq2 = f(mq2, op, d, 2, srv, slv);
         end
      end
   endtask

   task automatic compare();
      logic mbusy;
      mbusy = (left_n > 0);
      chk("q1", q1, mq1);
      chk("rd1", {7'd0, rd1}, {7'd0, mq1[0]});
      chk("ld1", {7'd0, ld1}, {7'd0, mq1[7]});
      chk("busy1", {7'd0, busy1}, {7'd0, mbusy});
      chk("done1", {7'd0, done1}, {7'd0, mdone});
      chk("q2", q2, mq2);
      chk("rd2", {6'd0, rd2}, mq2 & 8'h03);
      chk("ld2", {6'd0, ld2}, mq2 >> 6);
      chk("busy2", {7'd0, busy2}, {7'd0, mbusy});
      chk("done2", {7'd0, done2}, {7'd0, mdone});
   endtask

   task automatic cyc(input logic rn, input logic [2:0] o,
                      input logic [7:0] dd,
                      input logic [1:0] sr, input logic [1:0] sl,
                      input logic st, input logic bd,
                      input logic [3:0] bc);
      reset_n = rn; op = o; d = dd; srv = sr; slv = sl;
      start = st; burst_dir = bd; burst_cnt = bc;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   initial begin
      mq1 = 0; mq2 = 0; left_n = 0; mdir = 0; mdone = 0;
      @(negedge clk);

      // reset beats LOAD
      cyc(0, 3'd3, 8'hA5, 0, 0, 0, 0, 0);
      chk("rst_q", q1, 8'h00);
      chk("rst_busy", {7'd0, busy1}, 8'h00);
      chk("rst_done", {7'd0, done1}, 8'h00);

      cyc(1, 3'd3, 8'hA5, 0, 0, 0, 0, 0);
      cyc(1, 3'd1, 8'h00, 2'b01, 0, 0, 0, 0);
      chk("shr", q1, 8'hD2);
      cyc(1, 3'd3, 8'hA5, 0, 0, 0, 0, 0);
      cyc(1, 3'd2, 8'h00, 0, 2'b00, 0, 0, 0);
      chk("shl", q1, 8'h4A);
      cyc(1, 3'd3, 8'hA5, 0, 0, 0, 0, 0);
      cyc(1, 3'd4, 8'h00, 0, 0, 0, 0, 0);
      chk("ror", q1, 8'hD2);
      cyc(1, 3'd3, 8'h81, 0, 0, 0, 0, 0);
      cyc(1, 3'd5, 8'h00, 0, 0, 0, 0, 0);
      chk("rol", q1, 8'h03);
      cyc(1, 3'd3, 8'h80, 0, 0, 0, 0, 0);
      cyc(1, 3'd6, 8'h00, 0, 0, 0, 0, 0);
      chk("asr", q1, 8'hC0);
      cyc(1, 3'd3, 8'hFF, 0, 0, 0, 0, 0);
      cyc(1, 3'd7, 8'h00, 0, 0, 0, 0, 0);
      chk("clr", q1, 8'h00);
      cyc(1, 3'd3, 8'hC1, 0, 0, 0, 0, 0);
      cyc(1, 3'd5, 8'h00, 0, 0, 0, 0, 0);
      chk("rol_s2", q2, 8'h07);

      // burst left x3, LOAD held throughout
      cyc(1, 3'd3, 8'h01, 0, 0, 0, 0, 0);
      cyc(1, 3'd3, 8'hFF, 0, 0, 1, 1, 4'd3);
`ifdef USR_BURST_EN
      chk("bl_hold", q1, 8'h01);
      chk("bl_busy0", {7'd0, busy1}, 8'h01);
      cyc(1, 3'd3, 8'hFF, 0, 0, 0, 0, 0);
      chk("bl_s1", q1, 8'h02);
      cyc(1, 3'd3, 8'hFF, 0, 0, 0, 0, 0);
      chk("bl_busy2", {7'd0, busy1}, 8'h01);
      chk("bl_done_early", {7'd0, done1}, 8'h00);
      cyc(1, 3'd3, 8'hFF, 0, 0, 0, 0, 0);
      chk("bl_q", q1, 8'h08);
      chk("bl_done", {7'd0, done1}, 8'h01);
      chk("bl_busy_end", {7'd0, busy1}, 8'h00);
      cyc(1, 3'd0, 8'h00, 0, 0, 0, 0, 0);
      chk("bl_done_1cyc", {7'd0, done1}, 8'h00);
`else
      chk("nb_load", q1, 8'hFF);
      chk("nb_busy", {7'd0, busy1}, 8'h00);
`endif

      // zero count: nothing starts, op runs
      cyc(1, 3'd3, 8'h5A, 0, 0, 1, 0, 4'd0);
      chk("z_busy", {7'd0, busy1}, 8'h00);
      chk("z_q", q1, 8'h5A);
      cyc(1, 3'd0, 8'h00, 0, 0, 0, 0, 0);
      chk("z_done", {7'd0, done1}, 8'h00);

      // start while busy is ignored
      cyc(1, 3'd3, 8'h80, 0, 0, 0, 0, 0);
      cyc(1, 3'd0, 8'h00, 0, 0, 1, 0, 4'd2);
      cyc(1, 3'd0, 8'h00, 0, 0, 1, 1, 4'd5);
      cyc(1, 3'd0, 8'h00, 0, 0, 1, 1, 4'd5);
`ifdef USR_BURST_EN
      chk("sb_q", q1, 8'h20);
      chk("sb_done", {7'd0, done1}, 8'h01);
`endif

      // reset at the second shift of a 5-burst
      cyc(1, 3'd3, 8'hFF, 0, 0, 0, 0, 0);
      cyc(1, 3'd0, 8'h00, 0, 0, 1, 0, 4'd5);
      cyc(1, 3'd0, 8'h00, 0, 0, 0, 0, 0);
      cyc(0, 3'd0, 8'h00, 0, 0, 0, 0, 0);
      chk("ab_q", q1, 8'h00);
      chk("ab_busy", {7'd0, busy1}, 8'h00);
      chk("ab_done", {7'd0, done1}, 8'h00);
      cyc(1, 3'd0, 8'h00, 0, 0, 0, 0, 0);
      chk("ab_done2", {7'd0, done1}, 8'h00);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 63) != 0),
             3'($urandom),
             8'($urandom),
             2'($urandom),
             2'($urandom),
             ($urandom_range(0, 5) == 0),
             1'($urandom),
             4'($urandom_range(0, 8)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
